mem_access_stage: RTL and testbench

Pipeline MEM stage sitting between the EX/MEM boundary and the byte-addressed data `Memory`. It drives `Memory`'s write, read and mask ports, and checks access size, alignment and range. It sign- or zero-extends load data. It registers the result into the MEM/WB pipeline register, using a valid/ready handshake on both sides. It also latches the first access fault in a sticky fault register.

---
 rtl/mem_access_stage.sv | 173 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Pipeline MEM stage between the EX/MEM boundary and a byte-addressed data
// Memory. It drives the Memory write/read/mask ports, checks access size,
// alignment and range, extends load data, and registers the result into a
// single-entry MEM/WB register with valid/ready handshakes on both sides.
// The first access fault is latched in a sticky fault register.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   inValid/inReady           EX/MEM handshake
//   inMemRead, inMemWrite     load / store request
//   inSize, inSigned          access size (00 b, 01 h, 10 w, 11 reserved), sign-extend
//   inAddr, inStoreData       effective address (or ALU result), store data
//   inRd, inRegWrite          writeback destination and enable
//   mem*                      to/from the attached Memory
//   outValid/outReady         MEM/WB handshake
//   outResult, outRd, outRegWrite  registered result
//   fault*                    sticky fault record, faultClear clears it
module mem_access_stage #(
    parameter int arg_addrWidth = 13
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic                     inMemRead,
    input  logic                     inMemWrite,
    input  logic [1:0]               inSize,
    input  logic                     inSigned,
    input  logic [31:0]              inAddr,
    input  logic [31:0]              inStoreData,
    input  logic [4:0]               inRd,
    input  logic                     inRegWrite,
    output logic                     memWriteEn,
    output logic [3:0]               memMask,
    output logic [arg_addrWidth-1:0] memWriteAddr,
    output logic [arg_addrWidth-1:0] memReadAddr,
    output logic [31:0]              memWriteData,
    input  logic [31:0]              memReadData,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [31:0]              outResult,
    output logic [4:0]               outRd,
    output logic                     outRegWrite,
    output logic                     faultValid,
    output logic [31:0]              faultAddr,
    output logic                     faultIsStore,
    output logic [1:0]               faultCause,
    input  logic                     faultClear
);

    localparam logic [1:0] CAUSE_MISALIGN = 2'b00;
    localparam logic [1:0] CAUSE_RANGE    = 2'b01;
    localparam logic [1:0] CAUSE_SIZE     = 2'b10;
    localparam logic [1:0] CAUSE_RDWR     = 2'b11;

    // One past the last byte address of the Memory.
    localparam logic [32:0] MEM_BYTES = 33'd1 << arg_addrWidth;

    logic        accept;
    logic        is_mem;
    logic [2:0]  nbytes;
    logic [32:0] limit;
    logic        acc_fault;
    logic [1:0]  cause;
    logic [31:0] load_data;

    // A stage in reset never accepts, which also blocks any store.
    assign inReady = rst && (!outValid || outReady);
    assign accept  = inValid && inReady;
    assign is_mem  = inMemRead || inMemWrite;

    always_comb begin
        case (inSize)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    // Lowest start address whose last byte falls outside memory; compared
    // on 33 bits so large 32-bit addresses cannot wrap.
    assign limit = MEM_BYTES - {30'd0, nbytes} + 33'd1;

    // Fault causes in priority order; non-memory ops never fault.
    always_comb begin
        acc_fault = 1'b0;
        cause     = CAUSE_MISALIGN;
        if (is_mem) begin
            if (inMemRead && inMemWrite) begin
                acc_fault = 1'b1;
                cause     = CAUSE_RDWR;
            end else if (inSize == 2'b11) begin
                acc_fault = 1'b1;
                cause     = CAUSE_SIZE;
            end else if ((inSize == 2'b01 && inAddr[0]) ||
                         (inSize == 2'b10 && inAddr[1:0] != 2'b00)) begin
                acc_fault = 1'b1;
                cause     = CAUSE_MISALIGN;
            end else if ({1'b0, inAddr} >= limit) begin
                acc_fault = 1'b1;
                cause     = CAUSE_RANGE;
            end
        end
    end

    always_comb begin
        memMask = 4'b0000;
        if (is_mem && !acc_fault) begin
            case (inSize)
                2'b00:   memMask = 4'b0001;
                2'b01:   memMask = 4'b0011;
                2'b10:   memMask = 4'b1111;
                default: memMask = 4'b0000;
            endcase
        end
    end

    assign memWriteEn   = accept && inMemWrite && !acc_fault;
    assign memWriteAddr = inAddr[arg_addrWidth-1:0];
    assign memReadAddr  = inAddr[arg_addrWidth-1:0];
    // Memory places bytes big-endian itself, so data goes out right-justified.
    assign memWriteData = inStoreData;

    // Read data arrives zero-filled, so only the signed case needs work.
    always_comb begin
        load_data = memReadData;
        if (inSigned) begin
            case (inSize)
                2'b00:   load_data = {{24{memReadData[7]}}, memReadData[7:0]};
                2'b01:   load_data = {{16{memReadData[15]}}, memReadData[15:0]};
                default: load_data = memReadData;
            endcase
        end
    end

    // MEM/WB register: a faulting op is consumed but leaves no beat behind.
    always_ff @(posedge clk) begin
        if (!rst) begin
            outValid    <= 1'b0;
            outResult   <= '0;
            outRd       <= '0;
            outRegWrite <= 1'b0;
        end else if (accept && !acc_fault) begin
            outValid    <= 1'b1;
            outResult   <= inMemRead ? load_data : inAddr;
            outRd       <= inRd;
            outRegWrite <= inRegWrite;
        end else if (outReady) begin
            outValid    <= 1'b0;
        end
    end

    // Sticky fault: first fault wins unless a clear arrives in the same
    // cycle, in which case the new fault is taken. A bare clear only drops
    // the valid flag and keeps the record.
    always_ff @(posedge clk) begin
        if (!rst) begin
            faultValid   <= 1'b0;
            faultAddr    <= '0;
            faultIsStore <= 1'b0;
            faultCause   <= CAUSE_MISALIGN;
        end else if (faultClear || (accept && acc_fault && !faultValid)) begin
            faultValid <= accept && acc_fault;
            if (accept && acc_fault) begin
                faultAddr    <= inAddr;
                faultIsStore <= inMemWrite;
                faultCause   <= cause;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: byte-array Memory model, table of single-op
// vectors, directed multi-cycle sequences, and randomized traffic checked
// against a transaction-level reference model.
module tb_mem_access_stage;

    localparam int AW  = 13;
    localparam int MSZ = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          inValid, inReady, inMemRead, inMemWrite, inSigned, inRegWrite;
    logic [1:0]    inSize;
    logic [31:0]   inAddr, inStoreData;
    logic [4:0]    inRd;
    logic          memWriteEn;
    logic [3:0]    memMask;
    logic [AW-1:0] memWriteAddr, memReadAddr;
    logic [31:0]   memWriteData, memReadData;
    logic          outValid, outReady, outRegWrite;
    logic [31:0]   outResult;
    logic [4:0]    outRd;
    logic          faultValid, faultIsStore, faultClear;
    logic [31:0]   faultAddr;
    logic [1:0]    faultCause;

    always #5 clk = ~clk;

    mem_access_stage #(.arg_addrWidth(AW)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
        .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inSize(inSize),
        .inSigned(inSigned), .inAddr(inAddr), .inStoreData(inStoreData),
        .inRd(inRd), .inRegWrite(inRegWrite), .memWriteEn(memWriteEn),
        .memMask(memMask), .memWriteAddr(memWriteAddr), .memReadAddr(memReadAddr),
        .memWriteData(memWriteData), .memReadData(memReadData),
        .outValid(outValid), .outReady(outReady), .outResult(outResult),
        .outRd(outRd), .outRegWrite(outRegWrite), .faultValid(faultValid),
        .faultAddr(faultAddr), .faultIsStore(faultIsStore),
        .faultCause(faultCause), .faultClear(faultClear)
    );

    // ---------------- Memory model (big-endian, falling-edge write) --------
    bit [7:0] mem    [MSZ];
    bit [7:0] refmem [MSZ];
    int       dut_writes = 0;
    int       exp_writes = 0;
    int       n_total = 0;
    int       n_bad   = 0;

    function automatic int mask_bytes(logic [3:0] m);
        case (m)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    always_comb begin
        memReadData = '0;
        for (int i = 0; i < 4; i++)
            if (i < mask_bytes(memMask))
                memReadData = {memReadData[23:0], mem[(int'(memReadAddr) + i) % MSZ]};
    end

    always @(negedge clk) begin
        if (memWriteEn === 1'b1) begin
            dut_writes <= dut_writes + 1;
            for (int i = 0; i < mask_bytes(memMask); i++)
                mem[(int'(memWriteAddr) + i) % MSZ] <=
                    8'(memWriteData >> (8 * (mask_bytes(memMask) - 1 - i)));
        end
    end

    // ---------------- Reference model -------------------------------------
    bit        m_ov, m_chk, m_rw, m_fv, m_fs;
    bit [31:0] m_res, m_fa;
    bit [4:0]  m_rd;
    bit [1:0]  m_fc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic void ref_fault(input bit rd, input bit wr, input bit [1:0] sz,
                                      input bit [31:0] a, output bit f, output bit [1:0] c);
        longint n;
        f = 1'b0;
        c = 2'b00;
        if (!(rd || wr)) return;
        f = 1'b1;
        if (rd && wr) c = 2'b11;
        else if (sz == 2'b11) c = 2'b10;
        else begin
            n = longint'(1) << sz;
            if (longint'({32'd0, a}) % n != 0) c = 2'b00;
            else if (longint'({32'd0, a}) + n > MSZ) c = 2'b01;
            else f = 1'b0;
        end
    endfunction

    function automatic bit [31:0] ref_load(input bit [1:0] sz, input bit sg, input bit [31:0] a);
        longint v = 0;
        int n = 1 << sz;
        for (int i = 0; i < n; i++) v = v * 256 + refmem[(a + 32'(i)) % MSZ];
        if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    // One clock of stimulus; entered and left 1 time unit after a rising edge.
    task automatic cycle(input bit v, input bit rd, input bit wr, input bit [1:0] sz,
                         input bit sg, input bit [31:0] a, input bit [31:0] sd,
                         input bit [4:0] r, input bit rw, input bit ordy,
                         input bit fclr, input bit rstv);
        bit f, rdy, acc, we;
        bit [1:0] c;
        bit [3:0] msk;
        int n;
        inValid = v; inMemRead = rd; inMemWrite = wr; inSize = sz; inSigned = sg;
        inAddr = a; inStoreData = sd; inRd = r; inRegWrite = rw;
        outReady = ordy; faultClear = fclr; rst = rstv;
        #1;
        ref_fault(rd, wr, sz, a, f, c);
        rdy = rstv && (!m_ov || ordy);
        acc = v && rdy;
        we  = acc && wr && !f;
        n   = 1 << sz;
        msk = (!f && (rd || wr)) ? 4'((1 << n) - 1) : 4'h0;
        chk("inReady", inReady, 32'(rdy));
        chk("memWriteEn", memWriteEn, 32'(we));
        chk("memMask", memMask, 32'(msk));
        if (rd || wr) begin
            chk("memWriteAddr", memWriteAddr, 32'(a[AW-1:0]));
            chk("memReadAddr", memReadAddr, 32'(a[AW-1:0]));
            chk("memWriteData", memWriteData, sd);
        end
        if (!rstv) begin
            m_ov = 0; m_chk = 0; m_res = 0; m_rd = 0; m_rw = 0;
            m_fv = 0; m_fa = 0; m_fs = 0; m_fc = 0;
        end else begin
            if (acc && !f) begin
                m_ov = 1; m_rd = r; m_rw = rw;
                m_chk = rd || !wr;
                m_res = rd ? ref_load(sz, sg, a) : a;
            end else if (ordy) m_ov = 0;
            if (fclr || (acc && f && !m_fv)) begin
                m_fv = acc && f;
                if (acc && f) begin m_fa = a; m_fs = wr; m_fc = c; end
            end
            if (we) begin
                exp_writes++;
                for (int i = 0; i < n; i++)
                    refmem[(a + 32'(i)) % MSZ] = 8'(sd >> (8 * (n - 1 - i)));
            end
        end
        @(posedge clk);
        #1;
        chk("outValid", outValid, 32'(m_ov));
        if (m_ov) begin
            chk("outRd", outRd, 32'(m_rd));
            chk("outRegWrite", outRegWrite, 32'(m_rw));
            if (m_chk) chk("outResult", outResult, m_res);
        end
        chk("faultValid", faultValid, 32'(m_fv));
        chk("faultAddr", faultAddr, m_fa);
        chk("faultIsStore", faultIsStore, 32'(m_fs));
        chk("faultCause", faultCause, 32'(m_fc));
    endtask

    task automatic idle(input bit ordy, input bit fclr);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, ordy, fclr, 1);
    endtask

    // ---------------- Table vectors ---------------------------------------
    typedef struct {
        bit rd, wr; bit [1:0] sz; bit sg; bit [31:0] a, sd;
        bit ef; bit [1:0] ec; bit [3:0] em; bit cr; bit [31:0] er;
    } vec_t;

    function automatic vec_t mk(bit rd, bit wr, bit [1:0] sz, bit sg, bit [31:0] a,
                                bit [31:0] sd, bit ef, bit [1:0] ec, bit [3:0] em,
                                bit cr, bit [31:0] er);
        vec_t t;
        t.rd = rd; t.wr = wr; t.sz = sz; t.sg = sg; t.a = a; t.sd = sd;
        t.ef = ef; t.ec = ec; t.em = em; t.cr = cr; t.er = er;
        return t;
    endfunction

    initial begin
        vec_t tbl[$];
        int w0, diffs;
        bit v, rd, wr, sg, ordy, fclr, rstv;
        bit [1:0] sz;
        bit [31:0] a;

        // reset
        cycle(1, 0, 1, 2, 0, 32'h10, 32'h1, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk("rst_outResult", outResult, 0);
        chk("rst_outRd", outRd, 0);
        chk("rst_outRegWrite", outRegWrite, 0);
        chk("rst_writes", dut_writes, 0);

        //             rd wr sz sg addr          data          ef ec    mask cr result
        tbl.push_back(mk(0, 1, 2, 0, 32'h10,       32'h80FF1234, 0, 0, 4'hF, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 32'h10,       0,            0, 0, 4'h1, 1, 32'hFFFFFF80));
        tbl.push_back(mk(1, 0, 0, 0, 32'h10,       0,            0, 0, 4'h1, 1, 32'h00000080));
        tbl.push_back(mk(1, 0, 1, 1, 32'h12,       0,            0, 0, 4'h3, 1, 32'h00001234));
        tbl.push_back(mk(1, 0, 1, 1, 32'h10,       0,            0, 0, 4'h3, 1, 32'hFFFF80FF));
        tbl.push_back(mk(1, 0, 1, 0, 32'h10,       0,            0, 0, 4'h3, 1, 32'h000080FF));
        tbl.push_back(mk(1, 0, 0, 1, 32'h11,       0,            0, 0, 4'h1, 1, 32'hFFFFFFFF));
        tbl.push_back(mk(1, 0, 2, 1, 32'h10,       0,            0, 0, 4'hF, 1, 32'h80FF1234));
        tbl.push_back(mk(0, 0, 2, 0, 32'hDEADBEEF, 0,            0, 0, 4'h0, 1, 32'hDEADBEEF));
        tbl.push_back(mk(0, 1, 0, 0, 32'h20,       32'h123456AB, 0, 0, 4'h1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 32'h20,       0,            0, 0, 4'h1, 1, 32'hFFFFFFAB));
        tbl.push_back(mk(1, 0, 2, 0, 32'h2,        0,            1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(1, 1, 2, 0, 32'h2,        0,            1, 3, 4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 3, 0, 32'h3,        0,            1, 2, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h1FFF,     0,            1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 32'h2000,     0,            1, 1, 4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 2, 0, 32'h1FFC,     0,            0, 0, 4'hF, 1, 32'h0));
        tbl.push_back(mk(1, 0, 2, 0, 32'h2000,     0,            1, 1, 4'h0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 32'h1FFF,     0,            0, 0, 4'h1, 1, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 32'hFFFFFFFF, 0,            1, 1, 4'h0, 0, 0));
        foreach (tbl[i]) begin
            cycle(1, tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].sd,
                  5'(i), 1, 1, 1, 1);
            chk($sformatf("tbl%0d_mask", i), memMask, 32'(tbl[i].em));
            chk($sformatf("tbl%0d_fault", i), faultValid, 32'(tbl[i].ef));
            chk($sformatf("tbl%0d_valid", i), outValid, 32'(!tbl[i].ef));
            if (tbl[i].ef) chk($sformatf("tbl%0d_cause", i), faultCause, 32'(tbl[i].ec));
            if (tbl[i].cr) chk($sformatf("tbl%0d_result", i), outResult, tbl[i].er);
        end
        chk("tbl_writes", dut_writes, 2);
        idle(1, 1);

        // first fault wins; a clear together with a new fault takes the new one
        cycle(1, 1, 0, 2, 0, 32'h2, 0, 1, 1, 1, 0, 1);
        chk("mis_fault", {faultValid, faultIsStore, faultCause}, {1'b1, 1'b0, 2'b00});
        chk("mis_addr", faultAddr, 32'h2);
        chk("mis_nobeat", outValid, 0);
        cycle(1, 0, 1, 1, 0, 32'h1FFF, 32'h55, 1, 0, 1, 0, 1);
        chk("hold_addr", faultAddr, 32'h2);
        cycle(1, 0, 1, 1, 0, 32'h2000, 32'h55, 1, 0, 1, 1, 1);
        chk("clr_new", {faultValid, faultIsStore, faultCause}, {1'b1, 1'b1, 2'b01});
        chk("clr_addr", faultAddr, 32'h2000);
        idle(1, 1);
        chk("clr_only", faultValid, 0);
        chk("clr_keep", faultCause, 32'h1);

        // back-pressure: store held off while the output is stalled
        cycle(1, 0, 0, 0, 0, 32'h77, 0, 3, 1, 0, 0, 1);
        w0 = dut_writes;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 1, 2, 0, 32'h40, 32'hCAFEF00D, 4, 0, 0, 0, 1);
            chk("bp_hold", outResult, 32'h77);
        end
        cycle(1, 0, 1, 2, 0, 32'h40, 32'hCAFEF00D, 4, 0, 1, 0, 1);
        idle(1, 0);
        chk("bp_once", dut_writes - w0, 1);
        cycle(1, 1, 0, 2, 0, 32'h40, 0, 4, 1, 1, 0, 1);
        chk("bp_data", outResult, 32'hCAFEF00D);

        // back-to-back ALU flow
        for (int i = 1; i <= 4; i++) begin
            cycle(1, 0, 0, 0, 0, 32'(i), 0, 5'(i), 1, 1, 0, 1);
            chk("b2b_valid", outValid, 1);
            chk("b2b_result", outResult, 32'(i));
        end
        idle(1, 0);

        // mid-stream reset with a pending entry and a presented store
        cycle(1, 1, 0, 2, 0, 32'h6, 0, 0, 0, 1, 0, 1);
        cycle(1, 0, 0, 0, 0, 32'h99, 0, 9, 1, 0, 0, 1);
        w0 = dut_writes;
        cycle(1, 0, 1, 2, 0, 32'h44, 32'h1, 9, 1, 1, 0, 0);
        chk("mrst_nowrite", dut_writes - w0, 0);
        chk("mrst_out", {outValid, outRegWrite, outRd}, 0);
        chk("mrst_result", outResult, 0);
        chk("mrst_fault", {faultValid, faultIsStore, faultCause}, 0);
        chk("mrst_faddr", faultAddr, 0);

        // randomized traffic
        for (int k = 0; k < 800; k++) begin
            int op;
            op   = $urandom_range(0, 19);
            v    = $urandom_range(0, 3) != 0;
            rd   = (op < 8) || (op == 19);
            wr   = (op >= 8 && op < 16) || (op == 19);
            sg   = $urandom_range(0, 1) != 0;
            sz   = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0, 1:    a = 32'($urandom_range(MSZ - 8, MSZ + 3));
                2:       a = $urandom;
                default: a = 32'($urandom_range(0, 63));
            endcase
            if ($urandom_range(0, 2) != 0 && sz != 2'b11) a = a & ~((32'd1 << sz) - 1);
            ordy = $urandom_range(0, 3) != 0;
            fclr = $urandom_range(0, 11) == 0;
            rstv = $urandom_range(0, 59) != 0;
            cycle(v, rd, wr, sz, sg, a, $urandom, 5'($urandom), 1'($urandom),
                  ordy, fclr, rstv);
        end
        idle(1, 0);

        chk("total_writes", dut_writes, exp_writes);
        diffs = 0;
        for (int i = 0; i < MSZ; i++) if (mem[i] != refmem[i]) diffs++;
        chk("mem_image", diffs, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
